exu_mc: RTL and testbench

Multi-cycle execute/load-store unit, parametrised successor to the single-cycle execute stage. Accepts one decoded instruction per valid/ready handshake and computes the ALU result, branch decision and next PC. Memory access goes through a request/response handshake port with byte-lane alignment, sign/zero extension and misalignment detection. Sits between the decode stage and the write-back stage; the memory port connects to the data-side bus arbiter.

---
 rtl/exu_mc.sv | 188 ++++++++++++++++++
 tb/tb_exu_mc.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_mc.sv
// Multi-cycle execute / load-store unit: ALU, branch resolution, next-PC and a
// request/response memory port with byte-lane alignment and load extension.
module exu_mc #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     pc,
    input  logic [XLEN-1:0]     imm,
    input  logic [XLEN-1:0]     data1,
    input  logic [XLEN-1:0]     data2,
    input  logic [1:0]          alu_a_sel,
    input  logic [1:0]          alu_b_sel,
    input  logic [3:0]          alu_op,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [2:0]          mem_op,
    input  logic                pca_sel,
    input  logic                pcb_sel,
    input  logic                branch,
    input  logic                ebreak,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     data_out,
    output logic [XLEN-1:0]     pc_next,
    output logic                misalign,
    output logic                trap,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [XLEN-1:0]     mem_req_addr,
    output logic                mem_req_wen,
    output logic [XLEN-1:0]     mem_req_wdata,
    output logic [XLEN/8-1:0]   mem_req_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rsp_rdata
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int SHW  = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t r_state, w_stateNext;

    logic [XLEN-1:0] r_dataOut, r_pcNext, r_memAddr, r_wdata;
    logic [NB-1:0]   r_wstrb;
    logic            r_misalign, r_ebreak, r_wen, r_isLoad;
    logic [OFFW-1:0] r_off;
    logic [2:0]      r_memOp;

    logic [XLEN-1:0] w_aluA, w_aluB, w_aluRes, w_pcNext, w_wdata;
    logic [SHW-1:0]  w_shamt;
    logic [OFFW-1:0] w_off, w_sizeMask;
    logic [NB-1:0]   w_strb;
    logic            w_isMem, w_misal;
    logic [XLEN-1:0] w_ldShift, w_ldExt;
    logic [7:0]      w_ldBits;
    logic            w_ldFill;

    always_comb begin
        w_aluA = data1;
        case (alu_a_sel)
            2'b00:   w_aluA = data1;
            2'b01:   w_aluA = pc;
            default: w_aluA = '0;
        endcase
        w_aluB = data2;
        case (alu_b_sel)
            2'b00:   w_aluB = data2;
            2'b01:   w_aluB = imm;
            2'b10:   w_aluB = XLEN'(4);
            default: w_aluB = '0;
        endcase
        w_shamt  = w_aluB[SHW-1:0];
        w_aluRes = '0;
        case (alu_op)
            4'd0:    w_aluRes = w_aluA + w_aluB;
            4'd1:    w_aluRes = w_aluA - w_aluB;
            4'd2:    w_aluRes = w_aluA << w_shamt;
            4'd3:    w_aluRes = XLEN'($signed(w_aluA) < $signed(w_aluB));
            4'd4:    w_aluRes = XLEN'(w_aluA < w_aluB);
            4'd5:    w_aluRes = w_aluA ^ w_aluB;
            4'd6:    w_aluRes = w_aluA >> w_shamt;
            4'd7:    w_aluRes = $signed(w_aluA) >>> w_shamt;
            4'd8:    w_aluRes = w_aluA | w_aluB;
            4'd9:    w_aluRes = w_aluA & w_aluB;
            4'd10:   w_aluRes = XLEN'(w_aluA == w_aluB);
            4'd11:   w_aluRes = XLEN'(w_aluA != w_aluB);
            4'd12:   w_aluRes = XLEN'($signed(w_aluA) < $signed(w_aluB));
            4'd13:   w_aluRes = XLEN'($signed(w_aluA) >= $signed(w_aluB));
            4'd14:   w_aluRes = XLEN'(w_aluA < w_aluB);
            default: w_aluRes = XLEN'(w_aluA >= w_aluB);
        endcase
    end

    // Access size comes from mem_op[1:0] (1/2/4/8 bytes); mem_op[2] selects zero-extension.
    always_comb begin
        w_isMem    = mem_read | mem_write;
        w_off      = w_aluRes[OFFW-1:0];
        w_sizeMask = OFFW'((4'd1 << mem_op[1:0]) - 4'd1);
        w_misal    = w_isMem && ((w_off & w_sizeMask) != '0);
        w_strb     = NB'((16'd1 << (5'd1 << mem_op[1:0])) - 16'd1) << w_off;
        w_wdata    = data2 << {w_off, 3'b000};
        if (branch && (w_aluRes == XLEN'(1)))
            w_pcNext = pc + imm;
        else
            w_pcNext = (pca_sel ? data1 : pc) + (pcb_sel ? imm : XLEN'(4));
    end

    always_comb begin
        w_ldShift = mem_rsp_rdata >> {r_off, 3'b000};
        w_ldBits  = 8'd8 << r_memOp[1:0];
        if (w_ldBits > 8'(XLEN))
            w_ldBits = 8'(XLEN);
        w_ldFill = ~r_memOp[2] & w_ldShift[SHW'(w_ldBits - 8'd1)];
        w_ldExt  = '0;
        for (int i = 0; i < XLEN; i++)
            w_ldExt[i] = (i < int'(w_ldBits)) ? w_ldShift[i] : w_ldFill;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_stateNext = (w_isMem && !w_misal) ? S_REQ : S_DONE;
            S_REQ:  if (mem_req_ready) w_stateNext = S_WAIT;
            S_WAIT: if (mem_rsp_valid) w_stateNext = S_DONE;
            S_DONE: if (out_ready) w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Results are captured at accept; a load overwrites data_out when its response lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dataOut  <= '0;
            r_pcNext   <= RESET_PC;
            r_misalign <= 1'b0;
            r_ebreak   <= 1'b0;
            r_memAddr  <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wen      <= 1'b0;
            r_isLoad   <= 1'b0;
            r_off      <= '0;
            r_memOp    <= '0;
        end else begin
            if (r_state == S_IDLE && in_valid) begin
                r_dataOut  <= w_misal ? '0 : w_aluRes;
                r_pcNext   <= w_pcNext;
                r_misalign <= w_misal;
                r_ebreak   <= ebreak;
                r_memAddr  <= {w_aluRes[XLEN-1:OFFW], {OFFW{1'b0}}};
                r_wdata    <= w_wdata;
                r_wstrb    <= w_strb;
                r_wen      <= mem_write;
                r_isLoad   <= mem_read & ~mem_write;
                r_off      <= w_off;
                r_memOp    <= mem_op;
            end
            if (r_state == S_WAIT && mem_rsp_valid && r_isLoad)
                r_dataOut <= w_ldExt;
        end
    end

    assign in_ready      = (r_state == S_IDLE);
    assign out_valid     = (r_state == S_DONE);
    assign trap          = (r_state == S_DONE) && out_ready && r_ebreak;
    assign data_out      = r_dataOut;
    assign pc_next       = r_pcNext;
    assign misalign      = r_misalign;
    assign mem_req_valid = (r_state == S_REQ);
    assign mem_req_addr  = r_memAddr;
    assign mem_req_wen   = r_wen;
    assign mem_req_wdata = r_wdata;
    assign mem_req_wstrb = r_wstrb;

endmodule

// File: tb/tb_exu_mc.sv
// Directed self-checking bench for exu_mc (XLEN=32 main instance plus an
// XLEN=64 instance used for the doubleword load).
module tb_exu_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] pc = '0, imm = '0, data1 = '0, data2 = '0;
    logic [1:0]  alu_a_sel = '0, alu_b_sel = '0;
    logic [3:0]  alu_op = '0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  mem_op = '0;
    logic        pca_sel = 1'b0, pcb_sel = 1'b0, branch = 1'b0, ebreak = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] data_out, pc_next;
    logic        misalign, trap;
    logic        mem_req_valid, mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic        mem_req_wen;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_rdata = '0;

    logic        xInValid = 1'b0, xInReady, xOutValid, xOutReady = 1'b0;
    logic [63:0] xPc = '0, xImm = '0, xData1 = '0, xData2 = '0;
    logic        xMemRead = 1'b0;
    logic [2:0]  xMemOp = '0;
    logic [63:0] xDataOut, xPcNext, xReqAddr, xReqWdata;
    logic        xMisalign, xTrap, xReqValid, xReqWen;
    logic        xReqReady = 1'b1, xRspValid = 1'b0;
    logic [7:0]  xReqWstrb;
    logic [63:0] xRspRdata = '0;

    int checks = 0;
    int errors = 0;

    exu_mc #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .imm(imm), .data1(data1), .data2(data2),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
        .mem_read(mem_read), .mem_write(mem_write), .mem_op(mem_op),
        .pca_sel(pca_sel), .pcb_sel(pcb_sel), .branch(branch), .ebreak(ebreak),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .pc_next(pc_next), .misalign(misalign), .trap(trap),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
    );

    exu_mc #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(xInValid), .in_ready(xInReady),
        .pc(xPc), .imm(xImm), .data1(xData1), .data2(xData2),
        .alu_a_sel(2'b00), .alu_b_sel(2'b01), .alu_op(4'd0),
        .mem_read(xMemRead), .mem_write(1'b0), .mem_op(xMemOp),
        .pca_sel(1'b0), .pcb_sel(1'b0), .branch(1'b0), .ebreak(1'b0),
        .out_valid(xOutValid), .out_ready(xOutReady), .data_out(xDataOut),
        .pc_next(xPcNext), .misalign(xMisalign), .trap(xTrap),
        .mem_req_valid(xReqValid), .mem_req_ready(xReqReady),
        .mem_req_addr(xReqAddr), .mem_req_wen(xReqWen),
        .mem_req_wdata(xReqWdata), .mem_req_wstrb(xReqWstrb),
        .mem_rsp_valid(xRspValid), .mem_rsp_rdata(xRspRdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] aSel, input logic [1:0] bSel,
                                 input logic [3:0] op, input logic mr, input logic mw,
                                 input logic [2:0] mop, input logic pcaS, input logic pcbS,
                                 input logic br, input logic eb, input logic [31:0] pcV,
                                 input logic [31:0] immV, input logic [31:0] d1V,
                                 input logic [31:0] d2V);
        alu_a_sel = aSel; alu_b_sel = bSel; alu_op = op;
        mem_read = mr; mem_write = mw; mem_op = mop;
        pca_sel = pcaS; pcb_sel = pcbS; branch = br; ebreak = eb;
        pc = pcV; imm = immV; data1 = d1V; data2 = d2V;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic waitOut(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        if (!out_valid)
            checkOutput(tag, 64'(out_valid), 64'd1);
    endtask

    task automatic finishOut();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        checkOutput("rst out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst pc_next", 64'(pc_next), 64'h8000_0000);
        checkOutput("rst data_out", 64'(data_out), 64'd0);
        checkOutput("rst req_valid", 64'(mem_req_valid), 64'd0);
        checkOutput("rst misalign", 64'(misalign), 64'd0);
        checkOutput("rst trap", 64'(trap), 64'd0);

        // add wraps to zero, latency one
        applyStimulus(2'b00, 2'b01, 4'd0, 0, 0, 3'b000, 0, 0, 0, 0,
                      32'h100, 32'h1, 32'hFFFF_FFFF, 32'h0);
        checkOutput("add out_valid", 64'(out_valid), 64'd1);
        checkOutput("add in_ready", 64'(in_ready), 64'd0);
        checkOutput("add data", 64'(data_out), 64'd0);
        checkOutput("add pc_next", 64'(pc_next), 64'h104);
        finishOut();

        applyStimulus(2'b00, 2'b01, 4'd7, 0, 0, 3'b000, 0, 0, 0, 0,
                      32'h100, 32'h4, 32'h8000_0000, 32'h0);
        waitOut("sra timeout");
        checkOutput("sra data", 64'(data_out), 64'hF800_0000);
        finishOut();

        applyStimulus(2'b00, 2'b00, 4'd11, 0, 0, 3'b000, 0, 0, 1, 0,
                      32'h8000_0010, 32'hFFFF_FFF8, 32'd3, 32'd5);
        waitOut("bne timeout");
        checkOutput("bne taken data", 64'(data_out), 64'd1);
        checkOutput("bne taken pc", 64'(pc_next), 64'h8000_0008);
        finishOut();

        applyStimulus(2'b00, 2'b00, 4'd11, 0, 0, 3'b000, 0, 0, 1, 0,
                      32'h8000_0010, 32'hFFFF_FFF8, 32'd3, 32'd3);
        waitOut("bne nt timeout");
        checkOutput("bne not taken pc", 64'(pc_next), 64'h8000_0014);
        finishOut();

        // jalr-like: link pc+4, target data1+imm
        applyStimulus(2'b01, 2'b10, 4'd0, 0, 0, 3'b000, 1, 1, 0, 0,
                      32'h300, 32'h10, 32'h1000, 32'h0);
        waitOut("jalr timeout");
        checkOutput("jalr link", 64'(data_out), 64'h304);
        checkOutput("jalr pc", 64'(pc_next), 64'h1010);
        finishOut();

        // store byte at offset 3 with request stalled three cycles
        mem_req_ready = 1'b0;
        applyStimulus(2'b00, 2'b01, 4'd0, 0, 1, 3'b000, 0, 0, 0, 0,
                      32'h40, 32'h3, 32'h8000_0000, 32'h0000_00AB);
        for (int i = 0; i < 3; i++) begin
            checkOutput("sb req_valid", 64'(mem_req_valid), 64'd1);
            checkOutput("sb addr", 64'(mem_req_addr), 64'h8000_0000);
            checkOutput("sb wstrb", 64'(mem_req_wstrb), 64'b1000);
            checkOutput("sb wdata", 64'(mem_req_wdata), 64'hAB00_0000);
            checkOutput("sb wen", 64'(mem_req_wen), 64'd1);
            step();
        end
        mem_req_ready = 1'b1;
        step();
        checkOutput("sb req dropped", 64'(mem_req_valid), 64'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hDEAD_BEEF;
        step();
        mem_rsp_valid = 1'b0;
        checkOutput("sb out_valid", 64'(out_valid), 64'd1);
        checkOutput("sb data ea", 64'(data_out), 64'h8000_0003);
        finishOut();

        // lh at offset 2: out_valid three edges after accept
        applyStimulus(2'b00, 2'b01, 4'd0, 1, 0, 3'b001, 0, 0, 0, 0,
                      32'h40, 32'h2, 32'h8000_0000, 32'h0);
        checkOutput("lh req_valid", 64'(mem_req_valid), 64'd1);
        checkOutput("lh wen", 64'(mem_req_wen), 64'd0);
        step();
        checkOutput("lh not early", 64'(out_valid), 64'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h8001_1234;
        step();
        mem_rsp_valid = 1'b0;
        checkOutput("lh latency", 64'(out_valid), 64'd1);
        checkOutput("lh data", 64'(data_out), 64'hFFFF_8001);
        finishOut();

        applyStimulus(2'b00, 2'b01, 4'd0, 1, 0, 3'b101, 0, 0, 0, 0,
                      32'h40, 32'h2, 32'h8000_0000, 32'h0);
        step();
        mem_rsp_valid = 1'b1;
        step();
        mem_rsp_valid = 1'b0;
        waitOut("lhu timeout");
        checkOutput("lhu data", 64'(data_out), 64'h0000_8001);
        finishOut();

        applyStimulus(2'b00, 2'b01, 4'd0, 1, 0, 3'b010, 0, 0, 0, 0,
                      32'h40, 32'h1, 32'h8000_0000, 32'h0);
        checkOutput("lw mis req", 64'(mem_req_valid), 64'd0);
        checkOutput("lw mis out_valid", 64'(out_valid), 64'd1);
        checkOutput("lw mis flag", 64'(misalign), 64'd1);
        checkOutput("lw mis data", 64'(data_out), 64'd0);
        finishOut();

        // backpressure with ebreak
        applyStimulus(2'b00, 2'b01, 4'd0, 0, 0, 3'b000, 0, 0, 0, 1,
                      32'h200, 32'd7, 32'd5, 32'h0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp out_valid", 64'(out_valid), 64'd1);
            checkOutput("bp data", 64'(data_out), 64'd12);
            checkOutput("bp pc", 64'(pc_next), 64'h204);
            checkOutput("bp in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp trap early", 64'(trap), 64'd0);
            checkOutput("bp misalign", 64'(misalign), 64'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        checkOutput("ebreak trap", 64'(trap), 64'd1);
        step();
        out_ready = 1'b0;
        checkOutput("trap after", 64'(trap), 64'd0);
        checkOutput("bp idle", 64'(in_ready), 64'd1);

        // reset while waiting for a response, then a late response
        applyStimulus(2'b00, 2'b01, 4'd0, 1, 0, 3'b010, 0, 0, 0, 0,
                      32'h40, 32'h0, 32'h8000_0000, 32'h0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        step();
        mem_rsp_valid = 1'b0;
        checkOutput("rw in_ready", 64'(in_ready), 64'd1);
        checkOutput("rw out_valid", 64'(out_valid), 64'd0);
        checkOutput("rw pc_next", 64'(pc_next), 64'h8000_0000);
        checkOutput("rw req_valid", 64'(mem_req_valid), 64'd0);
        checkOutput("rw data", 64'(data_out), 64'd0);

        // XLEN=64 doubleword load
        xData1 = 64'h1000;
        xImm = 64'h0;
        xMemRead = 1'b1;
        xMemOp = 3'b011;
        xInValid = 1'b1;
        step();
        xInValid = 1'b0;
        checkOutput("ld req_valid", 64'(xReqValid), 64'd1);
        checkOutput("ld addr", xReqAddr, 64'h1000);
        step();
        xRspValid = 1'b1;
        xRspRdata = 64'h8877_6655_4433_2211;
        step();
        xRspValid = 1'b0;
        checkOutput("ld out_valid", 64'(xOutValid), 64'd1);
        checkOutput("ld data", xDataOut, 64'h8877_6655_4433_2211);
        xOutReady = 1'b1;
        step();
        xOutReady = 1'b0;
        checkOutput("ld idle", 64'(xInReady), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
